// File: rtl/axi2per_req_sched.sv
// ---------------------------------------------------------------------------
// axi2per_req_sched
//
// Request scheduler for the AXI-to-peripheral bridge. Picks one AXI read
// (AR) or write (AW+W together) request, turns it into a single 32-bit
// peripheral access and hands the control fields to the response channel.
// Only one access is ever outstanding. The next request is accepted only
// after the response channel reports trans_done_i.
//
// Optional feature macro: AXI2PER_SCHED_RR_EN
//   defined   : round-robin between reads and writes (prio_q)
//   undefined : fixed priority, reads always win
//
// Ports
//   clk_i, rst_i               clock, async active-high reset
//   axi_slave_ar_*             AR channel (valid/ready/addr/id)
//   axi_slave_aw_*             AW channel (valid/ready/addr/id/atop)
//   axi_slave_w_*              W channel  (valid/ready/data/strb)
//   per_master_*               peripheral request port (req/gnt/add/we/...)
//   trans_*_o                  control handed to the response channel
//   trans_r_valid_i            response channel presenting B/R (info only)
//   trans_done_i               final AXI response handshake done
//   busy_o                     scheduler not idle
// ---------------------------------------------------------------------------
module axi2per_req_sched #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 3,
    parameter int PER_ADDR_WIDTH = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    // AR
    input  logic                      axi_slave_ar_valid_i,
    output logic                      axi_slave_ar_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_ar_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_slave_ar_id_i,
    // AW
    input  logic                      axi_slave_aw_valid_i,
    output logic                      axi_slave_aw_ready_o,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_slave_aw_addr_i,
    input  logic [AXI_ID_WIDTH-1:0]   axi_slave_aw_id_i,
    input  logic [5:0]                axi_slave_aw_atop_i,
    // W
    input  logic                      axi_slave_w_valid_i,
    output logic                      axi_slave_w_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] axi_slave_w_data_i,
    input  logic [7:0]                axi_slave_w_strb_i,
    // peripheral master
    output logic                      per_master_req_o,
    output logic [PER_ADDR_WIDTH-1:0] per_master_add_o,
    output logic                      per_master_we_o,
    output logic [31:0]               per_master_wdata_o,
    output logic [3:0]                per_master_be_o,
    output logic [5:0]                per_master_atop_o,
    input  logic                      per_master_gnt_i,
    // response channel control
    output logic                      trans_req_o,
    output logic                      trans_we_o,
    output logic                      trans_atop_r_o,
    output logic [AXI_ID_WIDTH-1:0]   trans_id_o,
    output logic [AXI_ADDR_WIDTH-1:0] trans_add_o,
    input  logic                      trans_r_valid_i,
    input  logic                      trans_done_i,
    output logic                      busy_o
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t                    r_state;
    logic                      r_req;
    logic                      r_we;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [5:0]                r_atop;
    logic [31:0]               r_wdata;
    logic [3:0]                r_be;

    logic w_rd_cand, w_wr_cand, w_idle, w_sel_rd, w_sel_wr, w_hi;

    assign w_rd_cand = axi_slave_ar_valid_i;
    assign w_wr_cand = axi_slave_aw_valid_i & axi_slave_w_valid_i;
    // Readies are combinational; gate them with reset so every output is 0
    // while rst_i is held even if the masters keep valid asserted.
    assign w_idle    = (r_state == S_IDLE) & ~rst_i;

`ifdef AXI2PER_SCHED_RR_EN
    logic r_prio;  // 0: read first, 1: write first
    assign w_sel_rd = w_rd_cand & (~w_wr_cand | ~r_prio);
`else
    assign w_sel_rd = w_rd_cand;
`endif
    assign w_sel_wr = w_wr_cand & ~w_sel_rd;

    // 32-bit lane of the 64-bit W beat is chosen by addr[2]
    assign w_hi = axi_slave_aw_addr_i[2];

    assign axi_slave_ar_ready_o = w_idle & w_sel_rd;
    assign axi_slave_aw_ready_o = w_idle & w_sel_wr;
    assign axi_slave_w_ready_o  = w_idle & w_sel_wr;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_req   <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_id    <= '0;
            r_atop  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
`ifdef AXI2PER_SCHED_RR_EN
            r_prio  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_sel_rd) begin
                        r_we    <= 1'b1;
                        r_addr  <= axi_slave_ar_addr_i;
                        r_id    <= axi_slave_ar_id_i;
                        r_atop  <= '0;
                        r_wdata <= '0;
                        r_be    <= 4'hF;
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end else if (w_sel_wr) begin
                        r_we    <= 1'b0;
                        r_addr  <= axi_slave_aw_addr_i;
                        r_id    <= axi_slave_aw_id_i;
                        r_atop  <= axi_slave_aw_atop_i;
                        r_wdata <= w_hi ? axi_slave_w_data_i[63:32] : axi_slave_w_data_i[31:0];
                        r_be    <= w_hi ? axi_slave_w_strb_i[7:4]   : axi_slave_w_strb_i[3:0];
                        r_req   <= 1'b1;
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (per_master_gnt_i) begin
                        r_req   <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (trans_done_i) begin
                        r_state <= S_IDLE;
`ifdef AXI2PER_SCHED_RR_EN
                        // favour the class that was not just served
                        r_prio  <= r_we;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign per_master_req_o   = r_req;
    assign per_master_add_o   = r_addr[PER_ADDR_WIDTH-1:0];
    assign per_master_we_o    = r_we;
    assign per_master_wdata_o = r_wdata;
    assign per_master_be_o    = r_be;
    assign per_master_atop_o  = r_atop;

    // Pulse coincides with the grant handshake; r_req drops right after it.
    assign trans_req_o    = r_req & per_master_gnt_i;
    assign trans_we_o     = r_we;
    assign trans_atop_r_o = r_atop[5];
    assign trans_id_o     = r_id;
    assign trans_add_o    = r_addr;

    assign busy_o = (r_state != S_IDLE);

`ifndef SYNTHESIS
    // The response channel can only present B/R after the access was granted.
    always @(posedge clk_i) begin
        if (!rst_i && r_state != S_WAIT)
            assert (!trans_r_valid_i)
                else $error("trans_r_valid_i high outside Wait state");
    end
`endif

endmodule

// File: tb/tb_axi2per_req_sched.sv
module tb_axi2per_req_sched;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        ar_valid = 0, ar_ready;
    logic [31:0] ar_addr = 0;
    logic [2:0]  ar_id = 0;
    logic        aw_valid = 0, aw_ready;
    logic [31:0] aw_addr = 0;
    logic [2:0]  aw_id = 0;
    logic [5:0]  aw_atop = 0;
    logic        w_valid = 0, w_ready;
    logic [63:0] w_data = 0;
    logic [7:0]  w_strb = 0;
    logic        p_req, p_we, p_gnt = 0;
    logic [31:0] p_add, p_wdata;
    logic [3:0]  p_be;
    logic [5:0]  p_atop;
    logic        t_req, t_we, t_atop_r, t_rvalid = 0, t_done = 0, busy;
    logic [2:0]  t_id;
    logic [31:0] t_add;

    always #5 clk_i = ~clk_i;

    axi2per_req_sched dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .axi_slave_ar_valid_i(ar_valid), .axi_slave_ar_ready_o(ar_ready),
        .axi_slave_ar_addr_i(ar_addr), .axi_slave_ar_id_i(ar_id),
        .axi_slave_aw_valid_i(aw_valid), .axi_slave_aw_ready_o(aw_ready),
        .axi_slave_aw_addr_i(aw_addr), .axi_slave_aw_id_i(aw_id),
        .axi_slave_aw_atop_i(aw_atop),
        .axi_slave_w_valid_i(w_valid), .axi_slave_w_ready_o(w_ready),
        .axi_slave_w_data_i(w_data), .axi_slave_w_strb_i(w_strb),
        .per_master_req_o(p_req), .per_master_add_o(p_add), .per_master_we_o(p_we),
        .per_master_wdata_o(p_wdata), .per_master_be_o(p_be), .per_master_atop_o(p_atop),
        .per_master_gnt_i(p_gnt),
        .trans_req_o(t_req), .trans_we_o(t_we), .trans_atop_r_o(t_atop_r),
        .trans_id_o(t_id), .trans_add_o(t_add),
        .trans_r_valid_i(t_rvalid), .trans_done_i(t_done), .busy_o(busy)
    );

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  id;
        logic [31:0] add;
        logic [5:0]  atop;
        logic [31:0] wdata;
        logic [3:0]  be;
    } exp_t;

    exp_t q[$];

    typedef struct {
        logic        rd;
        logic [31:0] addr;
        logic [2:0]  id;
        logic [5:0]  atop;
        logic [63:0] data;
        logic [7:0]  strb;
        int          gnt_dly;
        int          w_dly;
        logic [31:0] e_wdata;
        logic [3:0]  e_be;
    } vec_t;

    // Scoreboard: every trans_req pulse must match the oldest expectation.
    always @(negedge clk_i) begin
        if (!rst_i && t_req) begin
            if (q.size() == 0) chk("unexpected_trans_req", 1, 0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("trans_we",    t_we,     e.we);
                chk("trans_id",    t_id,     e.id);
                chk("trans_add",   t_add,    e.add);
                chk("trans_atop_r", t_atop_r, e.atop[5]);
                chk("per_req",     p_req,    1);
                chk("per_add",     p_add,    e.add);
                chk("per_we",      p_we,     e.we);
                chk("per_be",      p_be,     e.be);
                chk("per_atop",    p_atop,   e.atop);
                if (!e.we) chk("per_wdata", p_wdata, e.wdata);
            end
        end
    end

    function automatic exp_t mk_exp(input vec_t v);
        exp_t e;
        e.we    = v.rd;
        e.id    = v.id;
        e.add   = v.addr;
        e.atop  = v.rd ? 6'h0 : v.atop;
        e.wdata = v.e_wdata;
        e.be    = v.e_be;
        return e;
    endfunction

    task automatic run_txn(input vec_t v);
        bit acc = 0;
        @(posedge clk_i); #1;
        if (v.rd) begin
            ar_valid = 1; ar_addr = v.addr; ar_id = v.id;
        end else begin
            aw_valid = 1; aw_addr = v.addr; aw_id = v.id; aw_atop = v.atop;
            w_data = v.data; w_strb = v.strb; w_valid = (v.w_dly == 0);
        end
        // AW alone must not be accepted
        for (int i = 0; i < v.w_dly; i++) begin
            @(negedge clk_i);
            chk("aw_without_w", {aw_ready, w_ready, busy}, 0);
        end
        if (!v.rd) begin
            if (v.w_dly != 0) begin @(posedge clk_i); #1; end
            w_valid = 1;
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (v.rd ? ar_ready : aw_ready) begin acc = 1; break; end
        end
        chk("accept", acc, 1);
        if (!v.rd) chk("w_ready_eq_aw_ready", w_ready, aw_ready);
        if (acc) q.push_back(mk_exp(v));
        @(posedge clk_i); #1;
        ar_valid = 0; aw_valid = 0; w_valid = 0;
        if (!acc) return;
        @(negedge clk_i);
        chk("req_1cyc_after_accept", p_req, 1);
        for (int i = 0; i < v.gnt_dly; i++) begin
            @(negedge clk_i);
            chk("req_held_no_gnt", {p_req, t_req}, 2'b10);
            chk("add_stable", p_add, v.addr);
        end
        @(posedge clk_i); #1; p_gnt = 1;
        @(negedge clk_i);
        chk("trans_req_on_gnt", t_req, 1);
        @(posedge clk_i); #1; p_gnt = 0; ar_valid = 1;  // probe: AR while waiting
        @(negedge clk_i);
        chk("wait_state", {t_req, p_req, ar_ready, busy}, 4'b0001);
        @(posedge clk_i); #1; ar_valid = 0; t_done = 1;
        @(posedge clk_i); #1; t_done = 0;
        @(negedge clk_i);
        chk("idle_after_done", busy, 0);
    endtask

    vec_t vt[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //         rd  addr           id    atop   data                    strb   gd wd  wdata          be
        vt[0] = '{1'b1, 32'h0000_1004, 3'd2, 6'h00, 64'h0,                   8'h00, 0, 0, 32'h0,         4'hF};
        vt[1] = '{1'b0, 32'h0000_2000, 3'd3, 6'h00, 64'hAABBCCDD_11223344,   8'hF0, 0, 0, 32'h11223344,  4'h0};
        vt[2] = '{1'b0, 32'h0000_2004, 3'd3, 6'h00, 64'hAABBCCDD_11223344,   8'hF0, 0, 0, 32'hAABBCCDD,  4'hF};
        vt[3] = '{1'b1, 32'h0000_7FFC, 3'd7, 6'h00, 64'h0,                   8'h00, 2, 0, 32'h0,         4'hF};
        vt[4] = '{1'b0, 32'h0000_5008, 3'd6, 6'h20, 64'h55667788_99AABBCC,   8'h0F, 4, 0, 32'h99AABBCC,  4'hF};
        vt[5] = '{1'b0, 32'h0000_600C, 3'd1, 6'h00, 64'hDEADBEEF_CAFEF00D,   8'h3C, 0, 3, 32'hDEADBEEF,  4'h3};

        // reset state
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        chk("reset_outputs", {ar_ready, aw_ready, w_ready, p_req, t_req, busy, p_be, p_add, t_id}, 0);
        @(posedge clk_i); #1; rst_i = 0;

        for (int k = 0; k < 6; k++) run_txn(vt[k]);

        // Simultaneous AR and AW+W for four transactions
        begin
            exp_t er, ew;
            bit found;
            er = '{1'b1, 3'd1, 32'h3000, 6'h0, 32'h0, 4'hF};
            ew = '{1'b0, 3'd5, 32'h4004, 6'h0, 32'h01234567, 4'hF};
`ifdef AXI2PER_SCHED_RR_EN
            q.push_back(er); q.push_back(ew); q.push_back(er); q.push_back(ew);
`else
            q.push_back(er); q.push_back(er); q.push_back(er); q.push_back(er);
`endif
            @(posedge clk_i); #1;
            ar_valid = 1; ar_addr = 32'h3000; ar_id = 3'd1;
            aw_valid = 1; aw_addr = 32'h4004; aw_id = 3'd5; aw_atop = 0;
            w_valid = 1; w_data = 64'h01234567_89ABCDEF; w_strb = 8'hFF;
            for (int k = 0; k < 4; k++) begin
                found = 0;
                if (k > 0) begin
                    @(negedge clk_i);
                    chk("b2b_accept_after_done", ar_ready | aw_ready, 1);
                    chk("one_ready_only", ar_ready & aw_ready, 0);
                end
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk_i);
                    if (p_req) begin found = 1; break; end
                end
                chk("prio_req_seen", found, 1);
                @(posedge clk_i); #1; p_gnt = 1;
                @(posedge clk_i); #1; p_gnt = 0; t_done = 1;
                if (k == 3) begin ar_valid = 0; aw_valid = 0; w_valid = 0; end
                @(posedge clk_i); #1; t_done = 0;
            end
            @(negedge clk_i);
            chk("prio_all_consumed", q.size(), 0);
        end

        // Reset while waiting for the response
        begin
            bit acc = 0;
            @(posedge clk_i); #1;
            ar_valid = 1; ar_addr = 32'h1234; ar_id = 3'd3;
            for (int i = 0; i < 10; i++) begin
                @(negedge clk_i);
                if (ar_ready) begin acc = 1; break; end
            end
            chk("rst_seq_accept", acc, 1);
            q.push_back('{1'b1, 3'd3, 32'h1234, 6'h0, 32'h0, 4'hF});
            @(posedge clk_i); #1; ar_valid = 0; p_gnt = 1;
            @(posedge clk_i); #1; p_gnt = 0;
            @(negedge clk_i);
            chk("rst_seq_in_wait", busy, 1);
            #2 rst_i = 1;
            @(negedge clk_i);
            chk("outputs_after_rst", {p_req, t_req, busy, ar_ready, aw_ready, w_ready,
                                      p_add, p_be, p_we, t_we, t_id, t_atop_r}, 0);
            chk("trans_add_after_rst", t_add, 0);
            @(posedge clk_i); #1; rst_i = 0;
            run_txn('{1'b1, 32'h0000_1008, 3'd4, 6'h00, 64'h0, 8'h00, 0, 0, 32'h0, 4'hF});
        end

        repeat (2) @(negedge clk_i);
        chk("scoreboard_empty", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
